// File: rtl/fir_arb_pkg.sv
// Shared types and constants for the FIR output arbiter.
package fir_arb_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } arb_state_e;

  localparam int MAX_CH = 8;
  localparam int CH_W   = $clog2(MAX_CH);
  localparam int STAT_W = 16;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first requester found starting at (last + 1) mod N.
module rr_picker
  import fir_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]    req,
  input  logic [CH_W-1:0] last,
  output logic [CH_W-1:0] gnt_idx,
  output logic            any
);

  int           c;
  logic [N-1:0] req_sh;

  // Walk from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    c       = 0;
    req_sh  = '0;
    for (int k = N; k >= 1; k--) begin
      c = int'(last) + k;
      if (c >= N) c = c - N;
      req_sh = req >> c;
      if (req_sh[0]) begin
        gnt_idx = CH_W'(c);
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fir_output_arbiter.sv
// Merges per-channel FIR results through 1-entry slots into one valid/ready stream.
// Optional FIR_ARB_STATS_EN adds per-channel accepted-result counters.
module fir_output_arbiter
  import fir_arb_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            fir_done,
  input  logic [NUM_CH*DATA_WIDTH-1:0] fir_dotProd,
  output logic [NUM_CH-1:0]            fir_rd_en,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [2:0]                   out_ch,
  output logic [NUM_CH-1:0]            err_overrun
`ifdef FIR_ARB_STATS_EN
  ,
  input  logic [2:0]                   stat_sel,
  output logic [STAT_W-1:0]            stat_count
`endif
);

  arb_state_e                           state_q, state_d;
  logic [NUM_CH-1:0]                    slot_full_q, slot_full_d;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0]    slot_data_q, slot_data_d;
  logic [NUM_CH-1:0]                    err_q, err_d;
  logic [DATA_WIDTH-1:0]                out_data_q, out_data_d;
  logic [CH_W-1:0]                      out_ch_q, out_ch_d;
  logic [CH_W-1:0]                      last_q, last_d;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0]    dot;
  logic [CH_W-1:0]                      pick_idx;
  logic                                 pick_any;
  logic                                 gnt;
  logic                                 drain;

  assign dot         = fir_dotProd;
  assign fir_rd_en   = ~slot_full_q;
  assign out_valid   = (state_q == PRESENT);
  assign out_data    = out_data_q;
  assign out_ch      = 3'(out_ch_q);
  assign err_overrun = err_q;

  rr_picker #(.N(NUM_CH)) u_rr (
    .req     (slot_full_q),
    .last    (last_q),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_ch_d   = out_ch_q;
    last_d     = last_q;
    gnt        = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt     = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          if (pick_any) gnt = 1'b1;
          else          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (gnt) begin
      out_ch_d = pick_idx;
      last_d   = pick_idx;
      for (int i = 0; i < NUM_CH; i++)
        if (pick_idx == CH_W'(i)) out_data_d = slot_data_q[i];
    end
  end

  // A slot being drained this cycle may be refilled in the same cycle without overrun.
  always_comb begin
    slot_full_d = slot_full_q;
    slot_data_d = slot_data_q;
    err_d       = err_q;
    drain       = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      drain = gnt && (pick_idx == CH_W'(i));
      if (fir_done[i]) begin
        if (!slot_full_q[i] || drain) begin
          slot_full_d[i] = 1'b1;
          slot_data_d[i] = dot[i];
        end else begin
          err_d[i] = 1'b1;
        end
      end else if (drain) begin
        slot_full_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      slot_full_q <= '0;
      slot_data_q <= '0;
      err_q       <= '0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      last_q      <= CH_W'(NUM_CH - 1);
    end else begin
      state_q     <= state_d;
      slot_full_q <= slot_full_d;
      slot_data_q <= slot_data_d;
      err_q       <= err_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      last_q      <= last_d;
    end
  end

`ifdef FIR_ARB_STATS_EN
  logic [NUM_CH-1:0][STAT_W-1:0] stat_q, stat_d;

  always_comb begin
    stat_d = stat_q;
    if (out_valid && out_ready)
      for (int i = 0; i < NUM_CH; i++)
        if (out_ch_q == CH_W'(i)) stat_d[i] = stat_q[i] + STAT_W'(1);
  end

  always_comb begin
    stat_count = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (stat_sel == 3'(i)) stat_count = stat_q[i];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) stat_q <= '0;
    else       stat_q <= stat_d;
  end
`endif

endmodule
